scroll_scan_ctrl: RTL and testbench

Timing and sequencing stage directly upstream of the character address calculator in the sliding-text display. Generates the 4-digit multiplex scan select, the matching active-low anode enables, and the scrolling window start index over the 12-character message. Window advances are deferred to scan-frame boundaries so a step never tears a displayed frame.

---
 rtl/scroll_pkg.sv | 12 +
 rtl/scroll_scan_ctrl_if.sv | 19 +
 rtl/tick_gen.sv | 18 +
 rtl/scroll_scan_ctrl.sv | 53 +++++
 tb/tb_scroll_scan_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/scroll_pkg.sv
// scroll_pkg: shared sizes and window-index stepping for the sliding-text display.
package scroll_pkg;
    localparam int MSG_LEN = 12;
    localparam int NUM_DIGITS = 4;
    localparam int IDX_W = 4;
    localparam int SEL_W = 2;
    localparam logic [IDX_W-1:0] IDX_WRAP = IDX_W'(MSG_LEN - 1);

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i, input logic rev);
        return rev ? (i == '0 ? IDX_WRAP : i - 1'b1) : (i == IDX_WRAP ? '0 : i + 1'b1);
    endfunction
endpackage

// File: rtl/scroll_scan_ctrl_if.sv
// scroll_scan_ctrl_if: control inputs and scan/window outputs; dir exists only with SCROLL_DIR_EN.
interface scroll_scan_ctrl_if;
    import scroll_pkg::*;
    logic run;
`ifdef SCROLL_DIR_EN
    logic dir;
`endif
    logic [IDX_W-1:0] win_idx;
    logic [SEL_W-1:0] scan_sel;
    logic [NUM_DIGITS-1:0] an;
    logic step;
`ifdef SCROLL_DIR_EN
    modport master(output run, dir, input win_idx, scan_sel, an, step);
    modport slave(input run, dir, output win_idx, scan_sel, an, step);
`else
    modport master(output run, input win_idx, scan_sel, an, step);
    modport slave(input run, output win_idx, scan_sel, an, step);
`endif
endinterface

// File: rtl/tick_gen.sv
// tick_gen: modulo-N prescaler that advances while en is high and pulses tc on its terminal count.
module tick_gen #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tc
);
    localparam int W = (N > 1) ? $clog2(N) : 1;
    logic [W-1:0] cnt;
    assign tc = en && cnt == W'(N - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (tc) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/scroll_scan_ctrl.sv
// scroll_scan_ctrl: digit scan and frame-aligned scroll window stepping.
// SCROLL_DIR_EN adds the dir input and reverse stepping.
module scroll_scan_ctrl
    import scroll_pkg::*;
#(
    parameter int SCAN_DIV = 100_000,
    parameter int SLIDE_DIV = 50_000_000
) (
    input logic clk,
    input logic rst_n,
    scroll_scan_ctrl_if.slave bus
);
    if (SCAN_DIV < 2) begin : g_bad_scan
        $error("SCAN_DIV must be >= 2");
    end
    if (SLIDE_DIV < 4 * SCAN_DIV) begin : g_bad_slide
        $error("SLIDE_DIV must be >= 4*SCAN_DIV");
    end

    logic scan_tc, slide_tc, pending, frame, commit, rev;
    logic [SEL_W-1:0] nsel;

    tick_gen #(.N(SCAN_DIV)) u_scan (.clk(clk), .rst_n(rst_n), .en(1'b1), .tc(scan_tc));
    tick_gen #(.N(SLIDE_DIV)) u_slide (.clk(clk), .rst_n(rst_n), .en(bus.run), .tc(slide_tc));

`ifdef SCROLL_DIR_EN
    assign rev = bus.dir;
`else
    assign rev = 1'b0;
`endif
    assign nsel = bus.scan_sel + 1'b1;
    assign frame = scan_tc && bus.scan_sel == SEL_W'(NUM_DIGITS - 1);
    // a slide terminal landing on the boundary edge commits immediately
    assign commit = frame && (pending || slide_tc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.win_idx <= '0;
            bus.scan_sel <= '0;
            bus.an <= 4'b1110;
            bus.step <= 1'b0;
            pending <= 1'b0;
        end else begin
            bus.step <= commit;
            pending <= !commit && (pending || slide_tc);
            if (commit) bus.win_idx <= next_idx(bus.win_idx, rev);
            if (scan_tc) begin
                bus.scan_sel <= nsel;
                bus.an <= ~(4'b0001 << nsel);
            end
        end
    end
endmodule

// File: tb/tb_scroll_scan_ctrl.sv
// tb_scroll_scan_ctrl: directed stimulus with an arithmetic reference model; e counts rising edges since reset release.
module tb_scroll_scan_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    int checks = 0, failures = 0;
    int e = 0, runs = 0, mwin = 0, mpend = 0, mstep = 0;

    scroll_scan_ctrl_if bus();
    scroll_scan_ctrl #(.SCAN_DIV(4), .SLIDE_DIV(20)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at e=%0d: got %0d expected %0d", name, e, act, exp);
        end
    endtask

    // model: terminals every 20 running edges, frames every 16 edges, commits on frames
    always @(posedge clk) begin
        int tick, mdir;
        if (!rst_n) begin
            e = 0; runs = 0; mwin = 0; mpend = 0; mstep = 0;
        end else begin
            e++;
            tick = (bus.run && (runs + 1) % 20 == 0) ? 1 : 0;
            if (bus.run) runs++;
`ifdef SCROLL_DIR_EN
            mdir = bus.dir;
`else
            mdir = 0;
`endif
            mstep = (e % 16 == 0 && (mpend || tick)) ? 1 : 0;
            if (mstep) mwin = mdir ? (mwin + 11) % 12 : (mwin + 1) % 12;
            mpend = (!mstep && (mpend || tick)) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [3:0] xan;
            int xsel;
            xsel = (e / 4) % 4;
            xan = ~(4'b0001 << xsel);
            chk("scan_sel", int'(bus.scan_sel), xsel);
            chk("an", int'(bus.an), int'(xan));
            chk("win_idx", int'(bus.win_idx), mwin);
            chk("step", int'(bus.step), mstep);
        end
    end

    task automatic at_edge(input int n);
        while (e < n) @(negedge clk);
    endtask

    task automatic do_reset(input logic r);
        rst_n = 1'b0;
        bus.run = r;
`ifdef SCROLL_DIR_EN
        bus.dir = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_win", int'(bus.win_idx), 0);
        chk("rst_sel", int'(bus.scan_sel), 0);
        chk("rst_an", int'(bus.an), 4'b1110);
        chk("rst_step", int'(bus.step), 0);
    endtask

    task automatic mid_reset(input int n, input int win_before);
        do_reset(1'b1);
        at_edge(n);
        chk("pre_rst_win", int'(bus.win_idx), win_before);
        #1 rst_n = 1'b0;
        #1;
        chk("async_win", int'(bus.win_idx), 0);
        chk("async_sel", int'(bus.scan_sel), 0);
        chk("async_an", int'(bus.an), 4'b1110);
        chk("async_step", int'(bus.step), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        at_edge(16);
        chk("post_rst_no_step", int'(bus.step), 0);
        at_edge(31);
        chk("post_rst_win31", int'(bus.win_idx), 0);
        at_edge(32);
        chk("post_rst_win32", int'(bus.win_idx), 1);
        chk("post_rst_step32", int'(bus.step), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        do_reset(1'b0);
        at_edge(4);
        chk("idle_sel4", int'(bus.scan_sel), 1);
        chk("idle_an4", int'(bus.an), 4'b1101);
        at_edge(12);
        chk("idle_an12", int'(bus.an), 4'b0111);
        at_edge(16);
        chk("idle_sel16", int'(bus.scan_sel), 0);
        at_edge(40);
        chk("idle_win", int'(bus.win_idx), 0);

        do_reset(1'b1);
        at_edge(31);
        chk("run_win31", int'(bus.win_idx), 0);
        at_edge(32);
        chk("run_win32", int'(bus.win_idx), 1);
        chk("run_step32", int'(bus.step), 1);
        chk("model_win32", mwin, 1);
        at_edge(33);
        chk("run_step33", int'(bus.step), 0);
        at_edge(48);
        chk("run_win48", int'(bus.win_idx), 2);
        at_edge(64);
        chk("run_win64", int'(bus.win_idx), 3);
        at_edge(80);
        chk("same_edge_win80", int'(bus.win_idx), 4);
        chk("same_edge_step80", int'(bus.step), 1);
        at_edge(96);
        chk("same_edge_no_step96", int'(bus.step), 0);
        at_edge(239);
        chk("wrap_win239", int'(bus.win_idx), 11);
        at_edge(240);
        chk("wrap_win240", int'(bus.win_idx), 0);
        chk("model_win240", mwin, 0);

        do_reset(1'b1);
        at_edge(33);
        bus.run = 1'b0;
        at_edge(133);
        chk("frozen_win", int'(bus.win_idx), 1);
        bus.run = 1'b1;
        at_edge(143);
        chk("resume_win143", int'(bus.win_idx), 1);
        at_edge(144);
        chk("resume_win144", int'(bus.win_idx), 2);
        chk("resume_step144", int'(bus.step), 1);

        mid_reset(25, 0);
        mid_reset(41, 1);

`ifdef SCROLL_DIR_EN
        do_reset(1'b1);
        bus.dir = 1'b1;
        at_edge(32);
        chk("rev_win32", int'(bus.win_idx), 11);
        at_edge(35);
        bus.dir = 1'b0;
        at_edge(40);
        bus.dir = 1'b1;
        at_edge(48);
        chk("rev_win48", int'(bus.win_idx), 10);
        at_edge(50);
        bus.dir = 1'b0;
        at_edge(64);
        chk("fwd_win64", int'(bus.win_idx), 11);
`endif
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
